board_ram_writer: RTL
=====================

BOARD_RAM_WRITER -- requirements
Module: board_ram_writer

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning board width in blocks.
REQ-002 SHALL have parameter ROWS, default 24, meaning board height in blocks.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning request queue entries (power of two, minimum 2).
REQ-004 SHALL have port CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  tile-update request present.
REQ-007 SHALL have port req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_x  in  5  block column 0..COLS-1.
REQ-009 SHALL have port req_y  in  5  block row 0..ROWS-1.
REQ-010 SHALL have port req_type  in  4  new block type.
REQ-011 SHALL have port rom_addr  out  10  initial-board ROM address.
REQ-012 SHALL have port rom_q  in  4  ROM data, valid one cycle after rom_addr.
REQ-013 SHALL have port ram_addr  out  10  board RAM write address.
REQ-014 SHALL have port ram_data  out  4  board RAM write data.
REQ-015 SHALL have port ram_wren  out  1  board RAM write enable.
REQ-016 SHALL have port init_done  out  1  board copy complete.
REQ-017 SHALL have port req_err  out  1  one-cycle pulse, out-of-range request rejected.

Function
REQ-018 SHALL implement states INIT and RUN; reset enters INIT.
REQ-019 In INIT, rom_addr SHALL increment by 1 per cycle from 0 to COLS*ROWS-1 (767), then hold.
REQ-020 In INIT, each ROM word SHALL be written one cycle after its address: ram_wren=1, ram_addr=rom_addr delayed one cycle, ram_data=rom_q.
REQ-021 The cycle after the write to address 767, state SHALL become RUN and init_done SHALL go 1 and stay 1 until reset.
REQ-022 In INIT, req_ready SHALL be 0 and req_err SHALL be 0.
REQ-023 In RUN, req_ready SHALL equal NOT fifo_full, registered-state derived, no combinational path from req_valid.
REQ-024 A request SHALL be accepted only when req_valid and req_ready are both 1.
REQ-025 An accepted request with req_x>=COLS or req_y>=ROWS SHALL NOT be queued; req_err SHALL pulse 1 the following cycle.
REQ-026 In-range accepted requests SHALL be pushed to the FIFO in arrival order.
REQ-027 In RUN, when FIFO non-empty, one entry SHALL be popped per cycle and written: ram_wren=1, ram_addr=req_y*COLS+req_x (10-bit, no overflow for legal inputs), ram_data=req_type.
REQ-028 Latency: a request accepted at edge N into an empty FIFO SHALL appear on ram_wren/ram_addr/ram_data in the cycle after edge N+1.
REQ-029 Simultaneous push and pop SHALL keep the occupancy unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 When FIFO empty in RUN, ram_wren SHALL be 0; ram_addr/ram_data SHALL hold last values.
REQ-031 Writes to the same tile SHALL land in acceptance order; the last accepted value SHALL win.

Reset
REQ-032 On reset assertion, immediately: state=INIT, rom_addr=0, ram_addr=0, ram_data=0, ram_wren=0, init_done=0, req_ready=0, req_err=0, FIFO emptied.
REQ-033 Reset mid-INIT or mid-RUN SHALL discard queued requests and restart the copy from address 0 after release.

Configuration
REQ-034 Macro BOARD_WRITE_COUNT_EN SHALL, when defined, add port writes_done  out  16  count of RUN-state RAM writes, saturating at 65535, reset to 0.
REQ-035 Without BOARD_WRITE_COUNT_EN, the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-036 Reset release, ROM holding address mod 16 -> 768 writes with ram_data[i]=i mod 16, init_done=1 exactly 769 cycles after release, req_ready 0 throughout INIT.
REQ-037 RUN, single request x=5 y=3 type=2 -> one write ram_addr=101, ram_data=2, two edges after acceptance.
REQ-038 RUN, req_valid held high with 6 back-to-back requests -> all 6 written in order, no loss, occupancy never exceeds 4.
REQ-039 Request x=0 y=24 type=7 -> req_err pulses one cycle, no RAM write; next valid request x=31 y=23 -> ram_addr=767.
REQ-040 Reset asserted with 3 queued entries in RUN -> outputs zero immediately, no queued writes after release, INIT restarts at rom_addr=0.
REQ-041 BOARD_WRITE_COUNT_EN defined, 10 RUN writes -> writes_done=10; INIT writes not counted.

Source files
------------

// File: rtl/board_ram_writer.sv
// board_ram_writer: copies the initial board from ROM into board RAM, then serves tile-update requests.
// Latency: a ROM word is written 1 cycle after its address; a request accepted at edge N is written after edge N+1.
// Backpressure: req_ready is high only in RUN with the request queue not full; out-of-range requests are dropped.
//
// Optional feature: define BOARD_WRITE_COUNT_EN to add writes_done, a saturating count of RUN-state RAM writes.
// Ports: CLOCK_50/reset (async, active-high); req_valid/req_ready/req_x/req_y/req_type tile-update request;
//        rom_addr/rom_q initial-board ROM (1-cycle read); ram_addr/ram_data/ram_wren board RAM write port;
//        init_done board copy complete; req_err one-cycle pulse on a rejected out-of-range request.
module board_ram_writer #(
    parameter int COLS       = 32,
    parameter int ROWS       = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_x,
    input  logic [4:0]  req_y,
    input  logic [3:0]  req_type,
    output logic [9:0]  rom_addr,
    input  logic [3:0]  rom_q,
    output logic [9:0]  ram_addr,
    output logic [3:0]  ram_data,
    output logic        ram_wren,
    output logic        init_done,
`ifdef BOARD_WRITE_COUNT_EN
    output logic [15:0] writes_done,
`endif
    output logic        req_err
);
    localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(FIFO_DEPTH);
    localparam logic [9:0]    LP_LAST = 10'(COLS * ROWS - 1);
    localparam logic [5:0]    LP_COLS = 6'(COLS);
    localparam logic [5:0]    LP_ROWS = 6'(ROWS);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [3:0] data;
    } entry_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [9:0]    r_rom_addr;
    logic          r_src_rom;
    logic          r_wren;
    logic [9:0]    r_ram_addr;
    logic [3:0]    r_ram_data;
    logic          r_err;
    entry_t        r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_accept;
    logic          w_oor;
    logic          w_push;
    logic          w_pop;
    logic          w_copy_last;
    logic          w_copy_issue;
    logic [9:0]    w_addr;
    entry_t        w_in;

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_next;
    end

    // The write of the final ROM word is on the RAM bus this cycle.
    assign w_copy_last = r_src_rom && (r_ram_addr == LP_LAST);

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && w_copy_last) w_state_next = ST_RUN;
    end

    always_comb begin
        init_done = (r_state == ST_RUN);
        req_ready = (r_state == ST_RUN) && !w_full;
    end

    // ---------------- request intake ----------------
    assign w_full       = (r_count == LP_FULL);
    assign w_accept     = req_valid && req_ready;
    assign w_oor        = ({1'b0, req_x} >= LP_COLS) || ({1'b0, req_y} >= LP_ROWS);
    assign w_push       = w_accept && !w_oor;
    assign w_pop        = (r_state == ST_RUN) && (r_count != '0);
    assign w_addr       = 10'(req_y) * 10'(COLS) + 10'(req_x);
    assign w_in         = {w_addr, req_type};
    // Another ROM word still has to be copied (the final one has not reached the bus yet).
    assign w_copy_issue = (r_state == ST_INIT) && !w_copy_last;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_accept && w_oor;
    end

    // ---------------- request queue ----------------
    always_ff @(posedge CLOCK_50) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // ---------------- ROM address sweep ----------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                                          r_rom_addr <= '0;
        else if (r_state == ST_INIT && r_rom_addr != LP_LAST) r_rom_addr <= r_rom_addr + 10'd1;
    end

    // ---------------- RAM write port ----------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_src_rom  <= 1'b0;
            r_wren     <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
        end else begin
            r_src_rom <= w_copy_issue;
            r_wren    <= w_copy_issue || w_pop;
            // During the copy ram_data is taken straight from rom_q; capture it so the
            // last ROM word keeps being driven once the copy ends.
            if (r_src_rom) r_ram_data <= rom_q;
            if (w_copy_issue) begin
                r_ram_addr <= r_rom_addr;
            end else if (w_pop) begin
                r_ram_addr <= r_mem[r_rd_ptr].addr;
                r_ram_data <= r_mem[r_rd_ptr].data;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign ram_wren = r_wren;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_src_rom ? rom_q : r_ram_data;
    assign req_err  = r_err;

`ifdef BOARD_WRITE_COUNT_EN
    logic [15:0] r_writes;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                            r_writes <= '0;
        else if (w_pop && r_writes != 16'hFFFF) r_writes <= r_writes + 16'd1;
    end

    assign writes_done = r_writes;
`endif

endmodule
